// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit:
//   - opcode and funct codes
//   - ALU operation encodings (shared with alu_unit)
//   - FSM state encoding
//   - datapath mux-select codes
//   - a helper that identifies the states holding a memory request
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand A select
  localparam logic SRC_A_PC  = 1'b0;
  localparam logic SRC_A_REG = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRC_B_REGB   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // FSM states
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11
  } state_t;

  // True in the states that hold a memory request open until mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec
//   Combinational R-type funct decoder.
//   Ports:
//     funct   in  6  IR[5:0]
//     alu_op  out 3  ALU operation; ADD for unsupported functs
//     illegal out 1  funct is not supported
module mc_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  // Map each supported funct to its ALU operation and flag everything else
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle MIPS control unit (Moore FSM). Drives all datapath enables and
//   mux selects, stalls on the memory ready handshake, and flags illegal
//   instructions and memory timeouts.
//   Parameters:
//     MEM_TIMEOUT  max wait cycles for mem_ready per access (0 = wait forever)
//     ENABLE_ADDI  1 = decode addi, 0 = treat it as illegal
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     opcode, funct                     instruction fields
//     mem_ready                         memory completes the access this cycle
//     pc_write, pc_write_cond, iord     PC / address control
//     mem_read, mem_write, ir_write     memory and IR control
//     reg_dst, mem_to_reg, reg_write    register-file control
//     alu_src_a, alu_src_b, pc_src      mux selects
//     alu_op                            ALU operation
//     instr_done, illegal_instr, mem_err  status pulses
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_err
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t          state;
  state_t          next_state;
  logic [5:0]      opcode_q;
  logic [2:0]      alu_op_q;
  logic [CW-1:0]   wait_cnt;
  logic [2:0]      dec_alu_op;
  logic            dec_illegal;
  logic            mem_req;
  logic            timeout;
  logic            op_illegal;

  mc_alu_dec u_alu_dec (
    .funct   (funct),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign mem_req = is_mem_state(state);

  // A ready in the final allowed wait cycle completes the access instead of
  // timing out, hence the !mem_ready term.
  assign timeout = (MEM_TIMEOUT > 0) && mem_req && !mem_ready &&
                   (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // Opcode legality; addi is legal only when the build enables it
  always_comb begin
    op_illegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_illegal = 1'b0;
      OP_ADDI: op_illegal = !ENABLE_ADDI;
      default: op_illegal = 1'b1;
    endcase
  end

  // State register plus the opcode captured in DECODE (selects lw vs sw in
  // MEM_ADDR) and the ALU op captured in R_EXEC (held through R_WB)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      opcode_q <= '0;
      alu_op_q <= ALU_ADD;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) opcode_q <= opcode;
      if (state == ST_R_EXEC) alu_op_q <= dec_alu_op;
    end
  end

  // Wait counter: counts stalled cycles of a memory request. It also clears
  // on a timeout because FETCH -> FETCH is not a state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!mem_req || mem_ready || timeout || (next_state != state)) begin
      wait_cnt <= '0;
    end else if (MEM_TIMEOUT > 0) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready)    next_state = ST_DECODE;
        else if (timeout) next_state = ST_FETCH;
      end
      ST_DECODE: begin
        if (op_illegal) next_state = ST_FETCH;
        else begin
          case (opcode)
            OP_RTYPE:     next_state = ST_R_EXEC;
            OP_LW, OP_SW: next_state = ST_MEM_ADDR;
            OP_BEQ:       next_state = ST_BRANCH;
            OP_J:         next_state = ST_JUMP;
            OP_ADDI:      next_state = ST_I_EXEC;
            default:      next_state = ST_FETCH;
          endcase
        end
      end
      ST_MEM_ADDR: next_state = (opcode_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)    next_state = ST_MEM_WB;
        else if (timeout) next_state = ST_FETCH;
      end
      ST_MEM_WR: begin
        if (mem_ready || timeout) next_state = ST_FETCH;
      end
      ST_R_EXEC:  next_state = dec_illegal ? ST_FETCH : ST_R_WB;
      ST_I_EXEC:  next_state = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_I_WB: next_state = ST_FETCH;
      default:    next_state = ST_FETCH;
    endcase
  end

  // Output logic; everything is forced low while rst_n is asserted so an
  // aborted instruction can never issue a write-enable
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REGB;
    pc_src        = PC_SRC_ALU;
    alu_op        = ALU_AND;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    mem_err       = 1'b0;
    if (rst_n) begin
      mem_err = timeout;
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b     = SRC_B_IMM_SH;
          alu_op        = ALU_ADD;
          illegal_instr = op_illegal;
        end
        ST_MEM_ADDR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ADD;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        ST_R_EXEC: begin
          alu_src_a     = SRC_A_REG;
          alu_op        = dec_alu_op;
          illegal_instr = dec_illegal;
        end
        ST_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          alu_op     = alu_op_q;
          instr_done = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = SRC_A_REG;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALUOUT;
          instr_done    = 1'b1;
        end
        ST_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JUMP;
          instr_done = 1'b1;
        end
        ST_I_EXEC: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_ADD;
        end
        ST_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Scoreboard bench for mc_control_fsm (MEM_TIMEOUT = 4, ENABLE_ADDI = 1).
//   Each driven cycle pushes the expected control word; the negedge sampler
//   pops it and compares against the DUT outputs.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_err;
  } ctrl_t;

  typedef struct {
    string tag;
    ctrl_t exp;
    ctrl_t mask;
  } sb_entry_t;

  localparam ctrl_t ALL = '1;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic       instr_done, illegal_instr, mem_err;
  ctrl_t      got;

  sb_entry_t  sb[$];
  int         checks = 0;
  int         passes = 0;

  mc_control_fsm #(.MEM_TIMEOUT(4), .ENABLE_ADDI(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr),
    .mem_err       (mem_err)
  );

  assign got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                alu_op, instr_done, illegal_instr, mem_err};

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Drives one cycle of inputs and queues the control word expected for it
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input logic rdy, input ctrl_t exp, input ctrl_t mask);
    sb_entry_t e;
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Negedge sampler: compare the oldest queued expectation with the DUT
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      checkOutput(e.tag, 32'(got & e.mask), 32'(e.exp & e.mask));
    end
  end

  // Expected control words per state, written from the control table
  function automatic ctrl_t exp_fetch(input logic rdy);
    ctrl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
    c.ir_write = rdy;  c.pc_write  = rdy;
    return c;
  endfunction

  function automatic ctrl_t exp_decode(input logic ill);
    ctrl_t c = '0;
    c.alu_src_b = 2'b11; c.alu_op = 3'b010; c.illegal_instr = ill;
    return c;
  endfunction

  function automatic ctrl_t exp_mem_addr();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctrl_t exp_mem_rd();
    ctrl_t c = '0;
    c.mem_read = 1'b1; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t exp_mem_wb();
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t exp_mem_wr(input logic rdy);
    ctrl_t c = '0;
    c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = rdy;
    return c;
  endfunction

  function automatic ctrl_t exp_r_exec(input logic [2:0] op, input logic ill);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = op; c.illegal_instr = ill;
    return c;
  endfunction

  function automatic ctrl_t exp_r_wb(input logic [2:0] op);
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = op; c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t exp_branch();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b110; c.pc_write_cond = 1'b1;
    c.pc_src = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t exp_jump();
    ctrl_t c = '0;
    c.pc_write = 1'b1; c.pc_src = 2'b10; c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t exp_i_exec();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctrl_t exp_i_wb();
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    ctrl_t t;
    rst_n     = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h22;
    mem_ready = 1'b1;

    // Outputs held low during reset
    for (int i = 0; i < 3; i++) applyStimulus("reset_zero", 6'h00, 6'h22, 1'b1, '0, ALL);
    rst_n = 1'b1;

    // R-type sub: 4 cycles, instr_done in the 4th
    applyStimulus("r_fetch",  6'h00, 6'h22, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("r_decode", 6'h00, 6'h22, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("r_exec",   6'h00, 6'h22, 1'b1, exp_r_exec(3'b110, 1'b0), ALL);
    applyStimulus("r_wb",     6'h00, 6'h22, 1'b1, exp_r_wb(3'b110), ALL);

    // R-type slt and or
    applyStimulus("slt_fetch",  6'h00, 6'h2A, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("slt_decode", 6'h00, 6'h2A, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("slt_exec",   6'h00, 6'h2A, 1'b1, exp_r_exec(3'b111, 1'b0), ALL);
    applyStimulus("slt_wb",     6'h00, 6'h00, 1'b1, exp_r_wb(3'b111), ALL);
    applyStimulus("or_fetch",   6'h00, 6'h25, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("or_decode",  6'h00, 6'h25, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("or_exec",    6'h00, 6'h25, 1'b1, exp_r_exec(3'b001, 1'b0), ALL);
    applyStimulus("or_wb",      6'h00, 6'h25, 1'b1, exp_r_wb(3'b001), ALL);

    // lw with 3 wait cycles in MEM_RD: 8 cycles total
    applyStimulus("lw_fetch",  6'h23, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("lw_decode", 6'h23, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("lw_addr",   6'h00, 6'h00, 1'b1, exp_mem_addr(), ALL);
    for (int i = 0; i < 3; i++) applyStimulus("lw_rd_wait", 6'h00, 6'h00, 1'b0, exp_mem_rd(), ALL);
    applyStimulus("lw_rd_done", 6'h00, 6'h00, 1'b1, exp_mem_rd(), ALL);
    applyStimulus("lw_wb",      6'h00, 6'h00, 1'b1, exp_mem_wb(), ALL);

    // beq: 3 cycles
    applyStimulus("beq_fetch",  6'h04, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("beq_decode", 6'h04, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("beq_branch", 6'h00, 6'h00, 1'b1, exp_branch(), ALL);

    // Illegal opcode, then illegal funct; each returns straight to FETCH
    applyStimulus("ill_op_fetch",  6'h3F, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("ill_op_decode", 6'h3F, 6'h00, 1'b1, exp_decode(1'b1), ALL);
    applyStimulus("ill_fn_fetch",  6'h00, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("ill_fn_decode", 6'h00, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("ill_fn_exec",   6'h00, 6'h00, 1'b1, exp_r_exec(3'b010, 1'b1), ALL);

    // j: 3 cycles
    applyStimulus("j_fetch",  6'h02, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("j_decode", 6'h02, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("j_jump",   6'h00, 6'h00, 1'b1, exp_jump(), ALL);

    // addi: 4 cycles
    applyStimulus("addi_fetch",  6'h08, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("addi_decode", 6'h08, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("addi_exec",   6'h00, 6'h00, 1'b1, exp_i_exec(), ALL);
    applyStimulus("addi_wb",     6'h00, 6'h00, 1'b1, exp_i_wb(), ALL);

    // Fetch timeout after 4 waiting cycles; mem_read in that cycle is not checked
    for (int i = 0; i < 3; i++) applyStimulus("to_wait", 6'h02, 6'h00, 1'b0, exp_fetch(1'b0), ALL);
    t = exp_fetch(1'b0);
    t.mem_err = 1'b1;
    applyStimulus("to_err", 6'h02, 6'h00, 1'b0, t, ALL ^ ctrl_t'(20'h10000));
    // Restarted fetch: ready arrives on the 4th cycle and wins over the timeout
    for (int i = 0; i < 3; i++) applyStimulus("to2_wait", 6'h02, 6'h00, 1'b0, exp_fetch(1'b0), ALL);
    applyStimulus("to2_ready",  6'h02, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("to2_decode", 6'h02, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("to2_jump",   6'h00, 6'h00, 1'b1, exp_jump(), ALL);

    // sw: 4 cycles
    applyStimulus("sw_fetch",  6'h2B, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("sw_decode", 6'h2B, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("sw_addr",   6'h00, 6'h00, 1'b1, exp_mem_addr(), ALL);
    applyStimulus("sw_wr",     6'h00, 6'h00, 1'b1, exp_mem_wr(1'b1), ALL);

    // Second sw stalls in MEM_WR, then reset lands mid-cycle
    applyStimulus("sw2_fetch",  6'h2B, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("sw2_decode", 6'h2B, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("sw2_addr",   6'h00, 6'h00, 1'b1, exp_mem_addr(), ALL);
    applyStimulus("sw2_wr_wait", 6'h00, 6'h00, 1'b0, exp_mem_wr(1'b0), ALL);
    mem_ready = 1'b0;
    #1;
    checkOutput("sw2_wr_held", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_async_all", 32'(got), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus("rst_hold", 6'h02, 6'h00, 1'b0, '0, ALL);
    rst_n = 1'b1;

    // After release: FETCH with pc_write low until mem_ready
    for (int i = 0; i < 2; i++) applyStimulus("post_rst_wait", 6'h02, 6'h00, 1'b0, exp_fetch(1'b0), ALL);
    applyStimulus("post_rst_ready",  6'h02, 6'h00, 1'b1, exp_fetch(1'b1), ALL);
    applyStimulus("post_rst_decode", 6'h02, 6'h00, 1'b1, exp_decode(1'b0), ALL);
    applyStimulus("post_rst_jump",   6'h00, 6'h00, 1'b1, exp_jump(), ALL);

    @(negedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
